// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash write/erase initiator.
// Holds flash opcodes, cmd_op encodings, datapath widths and the sequencer state enum.
package spi_flash_pkg;

   localparam int unsigned SHIFT_W = 40;   // longest frame: opcode + addr + data
   localparam int unsigned CNT_W   = 6;    // frame bit/cycle counter
   localparam int unsigned GAP_W   = 16;   // cs-high gap / poll interval counter
   localparam int unsigned TMO_W   = 32;   // WIP timeout counter
   localparam int unsigned ADDR_W  = 24;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [7:0] CMD_WREN  = 8'h06;
   localparam logic [7:0] CMD_PP    = 8'h02;
   localparam logic [7:0] CMD_SE    = 8'h20;
   localparam logic [7:0] CMD_BE    = 8'hD8;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] CMD_FREAD = 8'h0B;

   localparam logic [1:0] OP_PROG = 2'b00;
   localparam logic [1:0] OP_SE   = 2'b01;
   localparam logic [1:0] OP_BE   = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_GAP1,
      ST_OP,
      ST_GAP2,
      ST_RDSR,
      ST_CHECK,
      ST_PWAIT
   } state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// One SPI transaction: cs falls, len_i bits of tx_data_i go out MSB first,
// optionally 8 bits are read back, then cs rises.
// Ports: start_i (accepted only while cs is high), len_i, rx_en_i, tx_data_i
// (left aligned), miso_i; cs_o, mosi_o, xfer_done_c_o (last cs-low cycle),
// rx_data_o (last received byte, updated at cs rise).
module spi_shift_engine
   import spi_flash_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic [CNT_W-1:0]   len_i,
   input  logic               rx_en_i,
   input  logic [SHIFT_W-1:0] tx_data_i,
   input  logic               miso_i,
   output logic               cs_o,
   output logic               mosi_o,
   output logic               xfer_done_c_o,
   output logic [BYTE_W-1:0]  rx_data_o
);

   logic               cs_q,   cs_d;
   logic               mosi_q, mosi_d;
   logic [SHIFT_W-1:0] sh_q,   sh_d;
   logic [CNT_W-1:0]   cnt_q,  cnt_d;
   logic [CNT_W-1:0]   len_q,  len_d;
   logic               rx_q,   rx_d;
   logic [BYTE_W-1:0]  rxsh_q, rxsh_d;
   logic [BYTE_W-1:0]  stat_q, stat_d;
   logic [CNT_W-1:0]   end_cnt;
   logic               last_c;

   // cnt_q equals the cycle offset from the cs fall; the frame ends after
   // len bits, plus 8 read cycles when receiving.
   always_comb begin
      end_cnt = rx_q ? CNT_W'(len_q + CNT_W'(8)) : len_q;
      last_c  = !cs_q && (cnt_q == end_cnt);
   end

   // Frame sequencing; bit k is registered at the end of offset k so it
   // appears on mosi during offset k+1.
   always_comb begin
      cs_d   = cs_q;
      mosi_d = mosi_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      len_d  = len_q;
      rx_d   = rx_q;
      rxsh_d = rxsh_q;
      stat_d = stat_q;
      if (cs_q) begin
         mosi_d = 1'b0;
         if (start_i) begin
            cs_d  = 1'b0;
            sh_d  = tx_data_i;
            cnt_d = '0;
            len_d = len_i;
            rx_d  = rx_en_i;
         end
      end else if (last_c) begin
         cs_d   = 1'b1;
         mosi_d = 1'b0;
         if (rx_q) stat_d = {rxsh_q[6:0], miso_i};
      end else begin
         mosi_d = sh_q[SHIFT_W-1];
         sh_d   = {sh_q[SHIFT_W-2:0], 1'b0};
         cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
         // First 7 read bits; the 8th is folded in at cs rise.
         if (rx_q && (cnt_q > len_q)) rxsh_d = {rxsh_q[6:0], miso_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cs_q   <= 1'b1;
         mosi_q <= 1'b0;
         sh_q   <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
         rx_q   <= 1'b0;
         rxsh_q <= '0;
         stat_q <= '0;
      end else begin
         cs_q   <= cs_d;
         mosi_q <= mosi_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         len_q  <= len_d;
         rx_q   <= rx_d;
         rxsh_q <= rxsh_d;
         stat_q <= stat_d;
      end
   end

   assign cs_o          = cs_q;
   assign mosi_o        = mosi_q;
   assign xfer_done_c_o = last_c;
   assign rx_data_o     = stat_q;

endmodule

// File: rtl/spi_flash_writer.sv
// SPI flash write/erase initiator: WREN, then page program / sector erase /
// block erase, then RDSR polling until WIP clears or the timeout expires.
// Ports: cmd_valid/cmd_op/addr/wdata request (accepted when ready),
// done/err completion pulse, status (last RDSR byte), cs/mosi/miso flash pins.
module spi_flash_writer
   import spi_flash_pkg::*;
#(
   parameter int unsigned CS_GAP        = 4,
   parameter int unsigned POLL_INTERVAL = 72,
   parameter int unsigned TIMEOUT       = 72_000_000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BYTE_W-1:0] wdata,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [BYTE_W-1:0] status,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   state_e              state_q, state_d;
   logic [GAP_W-1:0]    gap_q,   gap_d;
   logic [TMO_W-1:0]    tmo_q,   tmo_d;
   logic [1:0]          op_q,    op_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [BYTE_W-1:0]   wdata_q, wdata_d;
   logic                done_q,  done_d;
   logic                err_q,   err_d;
   logic                ready_q, ready_d;

   logic                xfer_start;
   logic [CNT_W-1:0]    xfer_len;
   logic                xfer_rx;
   logic [SHIFT_W-1:0]  xfer_tx;
   logic                xfer_done_c;
   logic [BYTE_W-1:0]   rdsr_byte;

   spi_shift_engine u_engine (
      .clk           (clk),
      .rstn          (rstn),
      .start_i       (xfer_start),
      .len_i         (xfer_len),
      .rx_en_i       (xfer_rx),
      .tx_data_i     (xfer_tx),
      .miso_i        (miso),
      .cs_o          (cs),
      .mosi_o        (mosi),
      .xfer_done_c_o (xfer_done_c),
      .rx_data_o     (rdsr_byte)
   );

   // Sequencer: a start is issued in the last cs-high cycle of each gap so the
   // engine's cs fall lands exactly CS_GAP / POLL_INTERVAL cycles after cs rise.
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      tmo_d      = (tmo_q == '1) ? tmo_q : TMO_W'(tmo_q + TMO_W'(1));
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      xfer_start = 1'b0;
      xfer_len   = CNT_W'(8);
      xfer_rx    = 1'b0;
      xfer_tx    = {CMD_WREN, 32'h0};
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               op_d    = cmd_op;
               addr_d  = addr;
               wdata_d = wdata;
               if (cmd_op == OP_RSVD) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  xfer_start = 1'b1;
                  state_d    = ST_WREN;
               end
            end
         end
         ST_WREN: begin
            if (xfer_done_c) begin
               gap_d   = GAP_W'(CS_GAP - 1);
               state_d = ST_GAP1;
            end
         end
         ST_GAP1: begin
            if (gap_q == '0) begin
               xfer_start = 1'b1;
               if (op_q == OP_PROG) begin
                  xfer_len = CNT_W'(40);
                  xfer_tx  = {CMD_PP, addr_q, wdata_q};
               end else begin
                  xfer_len = CNT_W'(32);
                  xfer_tx  = {(op_q == OP_SE) ? CMD_SE : CMD_BE, addr_q, 8'h00};
               end
               state_d = ST_OP;
            end else begin
               gap_d = GAP_W'(gap_q - GAP_W'(1));
            end
         end
         ST_OP: begin
            if (xfer_done_c) begin
               gap_d   = GAP_W'(CS_GAP - 1);
               state_d = ST_GAP2;
            end
         end
         ST_GAP2: begin
            if (gap_q == '0) begin
               xfer_start = 1'b1;
               xfer_rx    = 1'b1;
               xfer_tx    = {CMD_RDSR, 32'h0};
               tmo_d      = '0;   // timeout window opens at the first RDSR cs fall
               state_d    = ST_RDSR;
            end else begin
               gap_d = GAP_W'(gap_q - GAP_W'(1));
            end
         end
         ST_RDSR: begin
            if (xfer_done_c) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!rdsr_byte[0]) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (tmo_q >= TMO_W'(TIMEOUT)) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (POLL_INTERVAL <= 1) begin
               xfer_start = 1'b1;
               xfer_rx    = 1'b1;
               xfer_tx    = {CMD_RDSR, 32'h0};
               state_d    = ST_RDSR;
            end else begin
               // CHECK itself is the first cs-high cycle of the poll interval.
               gap_d   = GAP_W'(POLL_INTERVAL - 2);
               state_d = ST_PWAIT;
            end
         end
         ST_PWAIT: begin
            if (gap_q == '0) begin
               xfer_start = 1'b1;
               xfer_rx    = 1'b1;
               xfer_tx    = {CMD_RDSR, 32'h0};
               state_d    = ST_RDSR;
            end else begin
               gap_d = GAP_W'(gap_q - GAP_W'(1));
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         tmo_q   <= '0;
         op_q    <= OP_PROG;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign err    = err_q;
   assign status = rdsr_byte;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed bench for spi_flash_writer with a small flash model that records
// every cs-low frame (bits, length, preceding cs-high gap) and answers RDSR.
module tb_spi_flash_writer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [23:0] addr;
   logic [7:0]  wdata;
   logic        ready, done, err, cs, mosi;
   logic [7:0]  status;
   logic        miso = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_flash_writer #(.CS_GAP(4), .POLL_INTERVAL(72), .TIMEOUT(500)) dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
      .status(status), .cs(cs), .mosi(mosi), .miso(miso)
   );

   // Flash model / bus monitor
   int          nframes = 0;
   logic [63:0] fr_data [128];
   int          fr_len  [128];
   int          fr_gap  [128];
   bit          in_frame = 1'b0;
   int          pos = 0;
   int          cur_gap = 0;
   int          gap_acc = 0;
   logic [63:0] cur = '0;
   int          polls_left = 0;
   bit          stuck = 1'b0;
   bit          mon_en = 1'b0;
   int          idle_bad = 0;

   always @(negedge clk) begin
      miso = 1'b0;
      if (cs === 1'b0) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            pos = 0;
            cur = '0;
            cur_gap = gap_acc;
            gap_acc = 0;
         end else begin
            cur = {cur[62:0], mosi};
            pos++;
            // Present WIP as the LSB of the status byte, sampled at the end of offset 16.
            if (pos == 16 && cur[15:8] == 8'h05) begin
               if (stuck) miso = 1'b1;
               else if (polls_left > 0) begin
                  miso = 1'b1;
                  polls_left--;
               end
            end
         end
      end else begin
         if (in_frame) begin
            if (nframes < 128) begin
               fr_data[nframes] = cur;
               fr_len[nframes]  = pos;
               fr_gap[nframes]  = cur_gap;
            end
            nframes++;
            in_frame = 1'b0;
         end
         gap_acc++;
         if (mon_en && mosi !== 1'b0) idle_bad++;
      end
   end

   task automatic send_cmd(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; addr = a; wdata = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b exp 1", cs); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", mosi); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b exp 00", done, err); end
      checks++; if (status !== 8'h00) begin errors++; $display("FAIL rst_status got %h exp 00", status); end
      rstn = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_program;
      int b; bit ok;
      b = nframes; polls_left = 0;
      send_cmd(2'b00, 24'h400005, 8'hA5);
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL pp_done_wait got none exp done"); end
      checks++; if (err !== 1'b0 || status !== 8'h00 || ready !== 1'b1)
         begin errors++; $display("FAIL pp_result got err=%b st=%h rdy=%b exp 0 00 1", err, status, ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL pp_done_pulse got %b exp 0", done); end
      checks++; if (nframes - b !== 3) begin errors++; $display("FAIL pp_nframes got %0d exp 3", nframes - b); end
      checks++; if (fr_len[b] !== 8 || fr_data[b] !== 64'h06)
         begin errors++; $display("FAIL pp_wren got len %0d data %h exp 8 06", fr_len[b], fr_data[b]); end
      checks++; if (fr_len[b+1] !== 40 || fr_data[b+1] !== 64'h02400005A5 || fr_gap[b+1] !== 4)
         begin errors++; $display("FAIL pp_frame got len %0d data %h gap %0d exp 40 02400005a5 4", fr_len[b+1], fr_data[b+1], fr_gap[b+1]); end
      checks++; if (fr_len[b+2] !== 16 || fr_data[b+2] !== 64'h0500 || fr_gap[b+2] !== 4)
         begin errors++; $display("FAIL pp_rdsr got len %0d data %h gap %0d exp 16 0500 4", fr_len[b+2], fr_data[b+2], fr_gap[b+2]); end
   endtask

   task automatic test_erase;
      int b; bit ok;
      b = nframes; polls_left = 3;
      send_cmd(2'b01, 24'h401234, 8'h00);
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL se_done_wait got none exp done"); end
      checks++; if (err !== 1'b0 || status !== 8'h00)
         begin errors++; $display("FAIL se_result got err=%b st=%h exp 0 00", err, status); end
      checks++; if (nframes - b !== 6) begin errors++; $display("FAIL se_nframes got %0d exp 6", nframes - b); end
      checks++; if (fr_len[b+1] !== 32 || fr_data[b+1] !== 64'h20401234 || fr_gap[b+1] !== 4)
         begin errors++; $display("FAIL se_frame got len %0d data %h gap %0d exp 32 20401234 4", fr_len[b+1], fr_data[b+1], fr_gap[b+1]); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (fr_len[b+2+k] !== 16 || fr_data[b+2+k] !== 64'h0500 || fr_gap[b+2+k] !== ((k == 0) ? 4 : 72))
            begin errors++; $display("FAIL se_poll%0d got len %0d data %h gap %0d exp 16 0500 %0d", k, fr_len[b+2+k], fr_data[b+2+k], fr_gap[b+2+k], (k == 0) ? 4 : 72); end
      end
   endtask

   task automatic test_timeout;
      int b; bit ok;
      b = nframes; stuck = 1'b1;
      send_cmd(2'b10, 24'h123456, 8'h00);
      wait_done(4000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_done_wait got none exp done"); end
      checks++; if (err !== 1'b1 || status !== 8'h01 || cs !== 1'b1 || ready !== 1'b1)
         begin errors++; $display("FAIL to_result got err=%b st=%h cs=%b rdy=%b exp 1 01 1 1", err, status, cs, ready); end
      checks++; if (fr_len[b+1] !== 32 || fr_data[b+1] !== 64'hD8123456)
         begin errors++; $display("FAIL to_be_frame got len %0d data %h exp 32 d8123456", fr_len[b+1], fr_data[b+1]); end
      // Checks see 17,106,195,284,373,462,551 cycles since first poll: 7 polls.
      checks++; if (nframes - b !== 9) begin errors++; $display("FAIL to_nframes got %0d exp 9", nframes - b); end
      stuck = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reserved;
      int b; bit cs_low;
      b = nframes; cs_low = 1'b0;
      send_cmd(2'b11, 24'h00ABCD, 8'h77);
      checks++; if (done !== 1'b1 || err !== 1'b1 || ready !== 1'b1)
         begin errors++; $display("FAIL rsvd_pulse got done=%b err=%b rdy=%b exp 1 1 1", done, err, ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || err !== 1'b0)
         begin errors++; $display("FAIL rsvd_one_cycle got done=%b err=%b exp 0 0", done, err); end
      for (int i = 0; i < 10; i++) begin
         if (cs !== 1'b1) cs_low = 1'b1;
         @(negedge clk);
      end
      checks++; if (cs_low || nframes !== b)
         begin errors++; $display("FAIL rsvd_bus got cs_low=%b frames %0d exp 0 0", cs_low, nframes - b); end
   endtask

   task automatic test_back_to_back;
      int b; bit ok;
      b = nframes; polls_left = 0;
      send_cmd(2'b00, 24'h000010, 8'h3C);
      repeat (20) @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0", ready); end
      cmd_valid = 1'b1; cmd_op = 2'b01; addr = 24'hFFFFFF; wdata = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(2000, ok);
      checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL b2b_first got ok=%b err=%b exp 1 0", ok, err); end
      cmd_valid = 1'b1; cmd_op = 2'b00; addr = 24'h000020; wdata = 8'h5A;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (ready !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL b2b_accept got rdy=%b done=%b exp 0 0", ready, done); end
      wait_done(2000, ok);
      checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL b2b_second got ok=%b err=%b exp 1 0", ok, err); end
      checks++; if (nframes - b !== 6) begin errors++; $display("FAIL b2b_nframes got %0d exp 6", nframes - b); end
      checks++; if (fr_data[b+1] !== 64'h020000103C || fr_data[b+4] !== 64'h020000205A)
         begin errors++; $display("FAIL b2b_pp got %h %h exp 020000103c 020000205a", fr_data[b+1], fr_data[b+4]); end
      // Only CHECK and the done cycle separate the last poll from the new WREN.
      checks++; if (fr_gap[b+3] !== 2 || fr_data[b+3] !== 64'h06)
         begin errors++; $display("FAIL b2b_gap got gap %0d data %h exp 2 06", fr_gap[b+3], fr_data[b+3]); end
   endtask

   task automatic test_reset_mid;
      int b; bit ok;
      b = nframes; polls_left = 0;
      send_cmd(2'b00, 24'h400005, 8'hA5);
      repeat (29) @(negedge clk);
      checks++; if (cs !== 1'b0 || nframes - b !== 1)
         begin errors++; $display("FAIL rm_in_pp got cs=%b frames %0d exp 0 1", cs, nframes - b); end
      rstn = 1'b0;
      @(negedge clk);
      checks++; if (cs !== 1'b1 || mosi !== 1'b0 || done !== 1'b0 || ready !== 1'b1)
         begin errors++; $display("FAIL rm_reset got cs=%b mosi=%b done=%b rdy=%b exp 1 0 0 1", cs, mosi, done, ready); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (ready !== 1'b1 || done !== 1'b0 || cs !== 1'b1)
         begin errors++; $display("FAIL rm_release got rdy=%b done=%b cs=%b exp 1 0 1", ready, done, cs); end
      b = nframes;
      send_cmd(2'b00, 24'h000001, 8'h81);
      wait_done(2000, ok);
      checks++; if (!ok || err !== 1'b0 || status !== 8'h00)
         begin errors++; $display("FAIL rm_after got ok=%b err=%b st=%h exp 1 0 00", ok, err, status); end
      checks++; if (nframes - b !== 3 || fr_len[b+1] !== 40 || fr_data[b+1] !== 64'h0200000181)
         begin errors++; $display("FAIL rm_frames got n=%0d len %0d data %h exp 3 40 0200000181", nframes - b, fr_len[b+1], fr_data[b+1]); end
   endtask

   task automatic test_idle_mosi;
      checks++; if (idle_bad !== 0) begin errors++; $display("FAIL idle_mosi got %0d exp 0", idle_bad); end
   endtask

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; addr = '0; wdata = '0;
      test_reset;
      test_program;
      test_erase;
      test_timeout;
      test_reserved;
      test_back_to_back;
      test_reset_mid;
      test_idle_mosi;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
